mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the RV32IM 5-stage pipeline. It consumes the EX/MEM pipeline register, which is fed by the EX stage result (alu_result) and the forwarded rs2 data.
- Issues load/store requests on a valid/ready data-memory port, then aligns and sign/zero-extends load data.
- Drives the MEM/WB pipeline register and its forwarding source.
- Stalls upstream stages while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width. Low ADDR_W bits of alu_result_i are used.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  EX/MEM holds a valid instruction
- alu_result_i  in  32  EX result: address for load/store, writeback value otherwise
- store_data_i  in  32  forwarded rs2 data for stores
- rd_addr_i  in  5  destination register
- reg_write_i  in  1  instruction writes rd
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- funct3_i  in  3  access size/sign (RISC-V load/store funct3)
- stall_o  out  1  hold IF/ID/EX and EX/MEM this cycle (combinational)
- dmem_req_valid_o  out  1  request valid
- dmem_req_ready_i  in  1  memory accepts request
- dmem_req_we_o  out  1  1 = store
- dmem_req_addr_o  out  ADDR_W  word-aligned address ([1:0]=0)
- dmem_req_wdata_o  out  32  lane-replicated store data
- dmem_req_be_o  out  4  byte enables (loads: 4'b1111)
- dmem_rsp_valid_i  in  1  load data valid
- dmem_rsp_rdata_i  in  32  load word
- wb_valid_o  out  1  MEM/WB valid
- wb_data_o  out  32  writeback value, also the MEM/WB forwarding value
- wb_rd_addr_o  out  5  MEM/WB rd
- wb_reg_write_o  out  1  MEM/WB write enable
- misalign_o  out  1  misaligned-access pulse (tied 0 without macro)

Behaviour:
- Reset: state IDLE. All wb_* outputs are 0, misalign_o is 0, dmem_req_valid_o is 0 and stall_o is 0 from the next cycle on.
- FSM states: IDLE, REQ, WAIT.
- Non-memory instruction (valid_i, no mem op):
  - Retires at the next edge with 1-cycle latency.
  - wb_data_o = alu_result_i.
  - wb_reg_write_o = reg_write_i and (rd_addr_i != 0).
- Memory op in IDLE:
  - dmem_req_valid_o is driven combinationally from the inputs.
  - The request (addr, we, wdata, be, funct3, byte offset, rd, reg_write) is captured into internal registers.
- Acceptance and state transitions:
  - Store accepted (ready=1): retires this edge. stall_o=0. wb_reg_write_o=0. Stay IDLE.
  - Load accepted: stall_o=1, go to WAIT.
  - Not accepted: stall_o=1, go to REQ.
- REQ:
  - dmem_req_valid_o=1 with the latched request, held stable until ready.
  - On ready: a store retires (stall_o=0 that cycle) and returns to IDLE; a load goes to WAIT.
- WAIT:
  - stall_o=1 until dmem_rsp_valid_i.
  - On rsp: load result = aligned/extended rsp data. Retire with wb_reg_write_o = latched reg_write and rd!=0. stall_o=0 that cycle. Return to IDLE.
- Response timing: responses arrive no earlier than the cycle after acceptance. dmem_rsp_valid_i is ignored in IDLE and REQ.
- Bubbles: any cycle without retirement registers wb_valid_o=0 and wb_reg_write_o=0. wb_data_o and wb_rd_addr_o hold their values.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{half}}.
  - SW: be = 4'b1111.
- Loads:
  - LB/LBU select byte addr[1:0] and sign/zero-extend.
  - LH/LHU select half addr[1] and sign/zero-extend.
  - LW takes the full word.
- Without MEM_MISALIGN_CHECK_EN: addr[0] is ignored for halfword accesses, and addr[1:0] is ignored for words.
- Reset mid-transaction: the transaction is abandoned. The next cycle is IDLE with req_valid=0, and a late response is ignored.

Optional Feature:
- MEM_MISALIGN_CHECK_EN: a halfword with addr[0]=1, or a word with addr[1:0]!=0:
  - is not issued (dmem_req_valid_o stays 0);
  - retires in 1 cycle with wb_valid_o=1 and wb_reg_write_o=0;
  - pulses misalign_o=1 for exactly that retire cycle.
- Without the macro, misalign_o is constant 0 and accesses are handled as above.

Decomposition:
- Package mem_pkg: funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
- One sub-module, load_align: combinational byte/half select plus sign/zero extension from (rdata, offset, funct3).

Test Plan:
- ADD result 0x0000_002A, rd=5, reg_write=1 -> next cycle: wb_valid_o=1, wb_data_o=0x2A, wb_rd_addr_o=5, wb_reg_write_o=1, stall_o=0 throughout.
- SB addr 0x1003, data 0x0000_00A5, ready=1 -> same cycle: req_addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5, we=1, stall_o=0; next cycle wb_reg_write_o=0.
- LB addr 0x2001, ready=1, rsp 2 cycles later with rdata 0x1234_80FF -> stall_o high 2 cycles, wb_data_o=0xFFFF_FF80; LBU gives 0x0000_0080.
- LW with ready=0 for 3 cycles -> req held stable with addr constant, stall_o=1 through REQ and WAIT; on rsp 0xDEAD_BEEF -> wb_data_o=0xDEADBEEF.
- rst asserted in WAIT, then rsp_valid pulsed -> no retire, wb_valid_o=0, state IDLE, req_valid=0.
- With MEM_MISALIGN_CHECK_EN: LH addr 0x3001 -> no request issued, misalign_o=1 one cycle, wb_reg_write_o=0.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access pipeline stage:
//   - RISC-V load/store funct3 encodings
//   - FSM state encoding (IDLE / REQ / WAIT)
//   - helpers for store lane steering and misalignment detection
// -----------------------------------------------------------------------------
package mem_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Byte enables for a store; funct3[1:0] carries the access size.
    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] offset);
        logic [3:0] be;
        case (funct3[1:0])
            F3_SB[1:0]: be = 4'b0001 << offset;
            F3_SH[1:0]: be = offset[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum across every lane it could land in, so the
    // byte enables alone pick the destination bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        logic [31:0] wd;
        case (funct3[1:0])
            F3_SB[1:0]: wd = {4{data[7:0]}};
            F3_SH[1:0]: wd = {2{data[15:0]}};
            default:    wd = data;
        endcase
        return wd;
    endfunction

    // Halfword with odd address, or word not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic m;
        case (funct3[1:0])
            F3_SH[1:0]: m = offset[0];
            F3_SW[1:0]: m = (offset != 2'b00);
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data alignment: picks the addressed byte/halfword out of
// the returned memory word and sign- or zero-extends it according to funct3.
// Ports:
//   rdata   in  32  word returned by data memory
//   offset  in  2   byte offset of the load address
//   funct3  in  3   RISC-V load funct3 (LB/LH/LW/LBU/LHU)
//   data    out 32  aligned, extended load result
// -----------------------------------------------------------------------------
import mem_pkg::*;

module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // offset[0] is deliberately ignored for halfwords
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the RV32IM 5-stage pipeline. Takes the EX/MEM
// register, issues loads/stores on a valid/ready data-memory port, aligns load
// data and drives the MEM/WB register (also the MEM/WB forwarding source).
//
// Handshake: a request transfers on any cycle where dmem_req_valid_o and
// dmem_req_ready_i are both 1; once valid is raised the request fields stay
// stable until that transfer. Load data is taken on a cycle with
// dmem_rsp_valid_i=1 while in WAIT only (never in the acceptance cycle).
//
// Optional feature (macro MEM_MISALIGN_CHECK_EN): misaligned halfword/word
// accesses are not issued; they retire in one cycle without a register write
// and pulse misalign_o. Without the macro misalign_o is tied 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i .. funct3_i      EX/MEM register contents
//   stall_o                  hold IF/ID/EX and EX/MEM this cycle (comb)
//   dmem_req_*               data-memory request channel
//   dmem_rsp_*               data-memory load response
//   wb_*                     MEM/WB register
//   misalign_o               misaligned-access pulse
//   dbg_state                current FSM state (debug)
// -----------------------------------------------------------------------------
import mem_pkg::*;

module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    output logic              stall_o,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic              dmem_req_we_o,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic [31:0]       dmem_req_wdata_o,
    output logic [3:0]        dmem_req_be_o,
    input  logic              dmem_rsp_valid_i,
    input  logic [31:0]       dmem_rsp_rdata_i,
    output logic              wb_valid_o,
    output logic [31:0]       wb_data_o,
    output logic [4:0]        wb_rd_addr_o,
    output logic              wb_reg_write_o,
    output logic              misalign_o,
    output logic [1:0]        dbg_state
);

    state_t state;

    // Latched request
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic [4:0]        rd_q;
    logic              reg_write_q;

    // Decoded view of the incoming EX/MEM contents
    logic              mem_op;
    logic              is_store;
    logic              mis;
    logic              issue;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    logic [3:0]        in_be;
    logic [31:0]       load_data;

    always_comb begin
        mem_op   = valid_i & (mem_read_i | mem_write_i);
        is_store = mem_write_i;
`ifdef MEM_MISALIGN_CHECK_EN
        mis      = mem_op & is_misaligned(funct3_i, alu_result_i[1:0]);
`else
        mis      = 1'b0;
`endif
        issue    = mem_op & ~mis;
        in_addr  = {alu_result_i[ADDR_W-1:2], 2'b00};
        in_wdata = store_wdata(funct3_i, store_data_i);
        in_be    = is_store ? store_be(funct3_i, alu_result_i[1:0]) : 4'b1111;
    end

    // Request channel and stall. In IDLE the request comes straight from the
    // inputs so a ready memory accepts it without a bubble.
    always_comb begin
        dmem_req_valid_o = 1'b0;
        dmem_req_we_o    = 1'b0;
        dmem_req_addr_o  = '0;
        dmem_req_wdata_o = 32'h0;
        dmem_req_be_o    = 4'h0;
        stall_o          = 1'b0;
        case (state)
            IDLE: begin
                dmem_req_valid_o = issue;
                dmem_req_we_o    = is_store;
                dmem_req_addr_o  = in_addr;
                dmem_req_wdata_o = in_wdata;
                dmem_req_be_o    = in_be;
                // an accepted store retires now; anything else must wait
                stall_o          = issue & ~(is_store & dmem_req_ready_i);
            end
            REQ: begin
                dmem_req_valid_o = 1'b1;
                dmem_req_we_o    = we_q;
                dmem_req_addr_o  = addr_q;
                dmem_req_wdata_o = wdata_q;
                dmem_req_be_o    = be_q;
                stall_o          = ~(we_q & dmem_req_ready_i);
            end
            WAIT: begin
                stall_o          = ~dmem_rsp_valid_i;
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata  (dmem_rsp_rdata_i),
        .offset (offset_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wb_valid_o     <= 1'b0;
            wb_data_o      <= 32'h0;
            wb_rd_addr_o   <= 5'd0;
            wb_reg_write_o <= 1'b0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= 32'h0;
            be_q           <= 4'h0;
            funct3_q       <= 3'd0;
            offset_q       <= 2'd0;
            rd_q           <= 5'd0;
            reg_write_q    <= 1'b0;
        end else begin
            // bubble unless something retires below
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (!mem_op) begin
                            wb_valid_o     <= 1'b1;
                            wb_data_o      <= alu_result_i;
                            wb_rd_addr_o   <= rd_addr_i;
                            wb_reg_write_o <= reg_write_i & (rd_addr_i != 5'd0);
                        end else if (mis) begin
                            wb_valid_o     <= 1'b1;
                        end else begin
                            addr_q      <= in_addr;
                            we_q        <= is_store;
                            wdata_q     <= in_wdata;
                            be_q        <= in_be;
                            funct3_q    <= funct3_i;
                            offset_q    <= alu_result_i[1:0];
                            rd_q        <= rd_addr_i;
                            reg_write_q <= reg_write_i;
                            if (dmem_req_ready_i) begin
                                if (is_store) begin
                                    wb_valid_o <= 1'b1;
                                end else begin
                                    state <= WAIT;
                                end
                            end else begin
                                state <= REQ;
                            end
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready_i) begin
                        if (we_q) begin
                            wb_valid_o <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid_i) begin
                        wb_valid_o     <= 1'b1;
                        wb_data_o      <= load_data;
                        wb_rd_addr_o   <= rd_q;
                        wb_reg_write_o <= reg_write_q & (rd_q != 5'd0);
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state == IDLE) & mis;
        end
    end
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_addr_i;
    logic        reg_write_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic        stall_o;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic        dmem_req_we_o;
    logic [31:0] dmem_req_addr_o;
    logic [31:0] dmem_req_wdata_o;
    logic [3:0]  dmem_req_be_o;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rsp_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_reg_write_o;
    logic        misalign_o;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .alu_result_i     (alu_result_i),
        .store_data_i     (store_data_i),
        .rd_addr_i        (rd_addr_i),
        .reg_write_i      (reg_write_i),
        .mem_read_i       (mem_read_i),
        .mem_write_i      (mem_write_i),
        .funct3_i         (funct3_i),
        .stall_o          (stall_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_req_we_o    (dmem_req_we_o),
        .dmem_req_addr_o  (dmem_req_addr_o),
        .dmem_req_wdata_o (dmem_req_wdata_o),
        .dmem_req_be_o    (dmem_req_be_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rsp_rdata_i (dmem_rsp_rdata_i),
        .wb_valid_o       (wb_valid_o),
        .wb_data_o        (wb_data_o),
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_reg_write_o   (wb_reg_write_o),
        .misalign_o       (misalign_o),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic mw, input logic [2:0] f3, input logic rdy);
        valid_i          = v;
        alu_result_i     = alu;
        store_data_i     = sd;
        rd_addr_i        = rd;
        reg_write_i      = rw;
        mem_read_i       = mr;
        mem_write_i      = mw;
        funct3_i         = f3;
        dmem_req_ready_i = rdy;
    endtask

    // Load issued with ready=1, response 'waits' cycles after the acceptance
    // cycle's following cycle (waits=0: response the cycle right after).
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_data, input logic exp_rw);
        set_op(1'b1, addr, 32'h0, rd, 1'b1, 1'b1, 1'b0, f3, 1'b1);
        #1;
        chk({tag, "_req_valid"}, 32'(dmem_req_valid_o), 32'd1);
        chk({tag, "_req_addr"},  dmem_req_addr_o, {addr[31:2], 2'b00});
        chk({tag, "_req_we"},    32'(dmem_req_we_o), 32'd0);
        chk({tag, "_req_be"},    32'(dmem_req_be_o), 32'hF);
        chk({tag, "_stall_acc"}, 32'(stall_o), 32'd1);
        tick();
        dmem_req_ready_i = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            chk({tag, "_stall_wait"}, 32'(stall_o), 32'd1);
            chk({tag, "_state_wait"}, 32'(dbg_state), 32'd2);
            chk({tag, "_req_off"},    32'(dmem_req_valid_o), 32'd0);
            tick();
        end
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_rdata_i = rdata;
        #1;
        chk({tag, "_stall_rsp"}, 32'(stall_o), 32'd0);
        tick();
        dmem_rsp_valid_i = 1'b0;
        valid_i          = 1'b0;
        mem_read_i       = 1'b0;
        chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd1);
        chk({tag, "_wb_data"},  wb_data_o, exp_data);
        chk({tag, "_wb_rd"},    32'(wb_rd_addr_o), 32'(rd));
        chk({tag, "_wb_rw"},    32'(wb_reg_write_o), 32'(exp_rw));
        chk({tag, "_state"},    32'(dbg_state), 32'd0);
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_wbv;
        logic [31:0] e_wbd;
        logic [4:0]  e_wbrd;
        logic        e_wbrw;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"add",     1'b1, 32'h0000_002A, 32'h0,         5'd5,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1,
                    1'b0, 32'h0,    4'h0,    32'h0,         1'b0, 1'b1, 32'h0000_002A, 5'd5,  1'b1};
        vecs[1] = '{"sb_off3", 1'b1, 32'h0000_1003, 32'h0000_00A5, 5'd9,  1'b0, 1'b0, 1'b1, 3'd0, 1'b1,
                    1'b1, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0000_002A, 5'd5,  1'b0};
        vecs[2] = '{"rd0",     1'b1, 32'h0000_0077, 32'h0,         5'd0,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1,
                    1'b0, 32'h0,    4'h0,    32'h0,         1'b0, 1'b1, 32'h0000_0077, 5'd0,  1'b0};
        vecs[3] = '{"sh_hi",   1'b1, 32'h0000_2002, 32'h1234_BEEF, 5'd3,  1'b0, 1'b0, 1'b1, 3'd1, 1'b1,
                    1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b1, 32'h0000_0077, 5'd0,  1'b0};
        vecs[4] = '{"sw",      1'b1, 32'h0000_3004, 32'hCAFE_F00D, 5'd3,  1'b0, 1'b0, 1'b1, 3'd2, 1'b1,
                    1'b1, 32'h3004, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0077, 5'd0,  1'b0};
        vecs[5] = '{"bubble",  1'b0, 32'h0000_0999, 32'h0,         5'd6,  1'b1, 1'b1, 1'b0, 3'd2, 1'b1,
                    1'b0, 32'h0,    4'h0,    32'h0,         1'b0, 1'b0, 32'h0000_0077, 5'd0,  1'b0};
        vecs[6] = '{"sb_off1", 1'b1, 32'h0000_1001, 32'h1234_563C, 5'd2,  1'b0, 1'b0, 1'b1, 3'd0, 1'b1,
                    1'b1, 32'h1000, 4'b0010, 32'h3C3C_3C3C, 1'b0, 1'b1, 32'h0000_0077, 5'd0,  1'b0};
        vecs[7] = '{"alu_x31", 1'b1, 32'hFFFF_FFFF, 32'h0,         5'd31, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                    1'b0, 32'h0,    4'h0,    32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1};
        vecs[8] = '{"alu_norw",1'b1, 32'h0000_0100, 32'h0,         5'd4,  1'b0, 1'b0, 1'b0, 3'd0, 1'b1,
                    1'b0, 32'h0,    4'h0,    32'h0,         1'b0, 1'b1, 32'h0000_0100, 5'd4,  1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst              = 1'b1;
        dmem_rsp_valid_i = 1'b0;
        dmem_rsp_rdata_i = 32'h0;
        set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_wb_data",  wb_data_o, 32'h0);
        chk("rst_wb_rd",    32'(wb_rd_addr_o), 32'd0);
        chk("rst_wb_rw",    32'(wb_reg_write_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_req_valid",32'(dmem_req_valid_o), 32'd0);
        chk("rst_stall",    32'(stall_o), 32'd0);
        chk("rst_state",    32'(dbg_state), 32'd0);

        // table of single-cycle operations
        foreach (vecs[i]) begin
            set_op(vecs[i].valid, vecs[i].alu, vecs[i].sdata, vecs[i].rd, vecs[i].rw,
                   vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].ready);
            #1;
            chk({vecs[i].name, "_req_valid"}, 32'(dmem_req_valid_o), 32'(vecs[i].e_req));
            chk({vecs[i].name, "_stall"},     32'(stall_o), 32'(vecs[i].e_stall));
            if (vecs[i].e_req) begin
                chk({vecs[i].name, "_addr"},  dmem_req_addr_o, vecs[i].e_addr);
                chk({vecs[i].name, "_be"},    32'(dmem_req_be_o), 32'(vecs[i].e_be));
                chk({vecs[i].name, "_wdata"}, dmem_req_wdata_o, vecs[i].e_wdata);
                chk({vecs[i].name, "_we"},    32'(dmem_req_we_o), 32'd1);
            end
            tick();
            chk({vecs[i].name, "_wb_valid"}, 32'(wb_valid_o), 32'(vecs[i].e_wbv));
            chk({vecs[i].name, "_wb_data"},  wb_data_o, vecs[i].e_wbd);
            chk({vecs[i].name, "_wb_rd"},    32'(wb_rd_addr_o), 32'(vecs[i].e_wbrd));
            chk({vecs[i].name, "_wb_rw"},    32'(wb_reg_write_o), 32'(vecs[i].e_wbrw));
            chk({vecs[i].name, "_misalign"}, 32'(misalign_o), 32'd0);
            chk({vecs[i].name, "_state"},    32'(dbg_state), 32'd0);
        end
        set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();

        // loads: extension and lane selection
        do_load("lb",    32'h0000_2001, 3'd0, 5'd7,  32'h1234_80FF, 1, 32'hFFFF_FF80, 1'b1);
        do_load("lbu",   32'h0000_2001, 3'd4, 5'd7,  32'h1234_80FF, 1, 32'h0000_0080, 1'b1);
        do_load("lb3",   32'h0000_2003, 3'd0, 5'd12, 32'h7F00_0000, 0, 32'h0000_007F, 1'b1);
        do_load("lh",    32'h0000_2002, 3'd1, 5'd8,  32'h8001_1234, 0, 32'hFFFF_8001, 1'b1);
        do_load("lhu",   32'h0000_2002, 3'd5, 5'd8,  32'h8001_1234, 0, 32'h0000_8001, 1'b1);
        do_load("lh_lo", 32'h0000_2000, 3'd1, 5'd0,  32'h8001_1234, 0, 32'h0000_1234, 1'b0);

        // LW with ready low for three cycles; request must stay stable even
        // if EX/MEM contents wiggle, and a stray response in REQ is ignored
        set_op(1'b1, 32'h0000_4000, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        #1;
        chk("lw_hold0_valid", 32'(dmem_req_valid_o), 32'd1);
        chk("lw_hold0_stall", 32'(stall_o), 32'd1);
        tick();
        chk("lw_state_req", 32'(dbg_state), 32'd1);
        alu_result_i     = 32'h0000_5554;
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_rdata_i = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lw_hold_valid", 32'(dmem_req_valid_o), 32'd1);
            chk("lw_hold_addr",  dmem_req_addr_o, 32'h0000_4000);
            chk("lw_hold_we",    32'(dmem_req_we_o), 32'd0);
            chk("lw_hold_stall", 32'(stall_o), 32'd1);
            tick();
            dmem_rsp_valid_i = 1'b0;
            chk("lw_hold_wbv", 32'(wb_valid_o), 32'd0);
        end
        dmem_req_ready_i = 1'b1;
        #1;
        chk("lw_acc_addr",  dmem_req_addr_o, 32'h0000_4000);
        chk("lw_acc_stall", 32'(stall_o), 32'd1);
        tick();
        dmem_req_ready_i = 1'b0;
        chk("lw_state_wait", 32'(dbg_state), 32'd2);
        chk("lw_wait_wbv",   32'(wb_valid_o), 32'd0);
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("lw_rsp_stall", 32'(stall_o), 32'd0);
        tick();
        dmem_rsp_valid_i = 1'b0;
        valid_i          = 1'b0;
        chk("lw_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("lw_wb_data",  wb_data_o, 32'hDEAD_BEEF);
        chk("lw_wb_rd",    32'(wb_rd_addr_o), 32'd10);
        chk("lw_wb_rw",    32'(wb_reg_write_o), 32'd1);
        tick();
        chk("lw_bubble_wbv", 32'(wb_valid_o), 32'd0);
        chk("lw_bubble_rw",  32'(wb_reg_write_o), 32'd0);
        chk("lw_bubble_hold",wb_data_o, 32'hDEAD_BEEF);

        // store that waits in REQ, then retires on ready with no stall
        set_op(1'b1, 32'h0000_5008, 32'h0BAD_F00D, 5'd1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        #1;
        chk("swq_stall0", 32'(stall_o), 32'd1);
        tick();
        dmem_req_ready_i = 1'b1;
        #1;
        chk("swq_valid", 32'(dmem_req_valid_o), 32'd1);
        chk("swq_we",    32'(dmem_req_we_o), 32'd1);
        chk("swq_addr",  dmem_req_addr_o, 32'h0000_5008);
        chk("swq_wdata", dmem_req_wdata_o, 32'h0BAD_F00D);
        chk("swq_stall", 32'(stall_o), 32'd0);
        tick();
        set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("swq_wbv",   32'(wb_valid_o), 32'd1);
        chk("swq_wbrw",  32'(wb_reg_write_o), 32'd0);
        chk("swq_state", 32'(dbg_state), 32'd0);
        tick();

        // reset while waiting for a load; late response must be dropped
        set_op(1'b1, 32'h0000_6000, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1);
        tick();
        chk("rstw_state_wait", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_rdata_i = 32'h1234_5678;
        #1;
        chk("rstw_state",     32'(dbg_state), 32'd0);
        chk("rstw_req_valid", 32'(dmem_req_valid_o), 32'd0);
        chk("rstw_stall",     32'(stall_o), 32'd0);
        chk("rstw_wbv0",      32'(wb_valid_o), 32'd0);
        tick();
        dmem_rsp_valid_i = 1'b0;
        chk("rstw_wbv",  32'(wb_valid_o), 32'd0);
        chk("rstw_wbrw", 32'(wb_reg_write_o), 32'd0);
        chk("rstw_wbd",  wb_data_o, 32'h0);

        // misaligned halfword / word handling
`ifdef MEM_MISALIGN_CHECK_EN
        set_op(1'b1, 32'h0000_3001, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1);
        #1;
        chk("mis_lh_req",   32'(dmem_req_valid_o), 32'd0);
        chk("mis_lh_stall", 32'(stall_o), 32'd0);
        tick();
        set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("mis_lh_pulse", 32'(misalign_o), 32'd1);
        chk("mis_lh_wbv",   32'(wb_valid_o), 32'd1);
        chk("mis_lh_wbrw",  32'(wb_reg_write_o), 32'd0);
        tick();
        chk("mis_lh_end",   32'(misalign_o), 32'd0);
        set_op(1'b1, 32'h0000_3002, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        chk("mis_sw_req",   32'(dmem_req_valid_o), 32'd0);
        tick();
        set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("mis_sw_pulse", 32'(misalign_o), 32'd1);
        chk("mis_sw_wbv",   32'(wb_valid_o), 32'd1);
        tick();
        chk("mis_sw_end",   32'(misalign_o), 32'd0);
`else
        set_op(1'b1, 32'h0000_2001, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
        #1;
        chk("odd_sh_req",   32'(dmem_req_valid_o), 32'd1);
        chk("odd_sh_addr",  dmem_req_addr_o, 32'h0000_2000);
        chk("odd_sh_be",    32'(dmem_req_be_o), 32'b0011);
        chk("odd_sh_wdata", dmem_req_wdata_o, 32'hABCD_ABCD);
        tick();
        chk("odd_sh_mis",   32'(misalign_o), 32'd0);
        chk("odd_sh_wbv",   32'(wb_valid_o), 32'd1);
        set_op(1'b1, 32'h0000_3002, 32'h0BAD_CAFE, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
        #1;
        chk("odd_sw_addr",  dmem_req_addr_o, 32'h0000_3000);
        chk("odd_sw_be",    32'(dmem_req_be_o), 32'hF);
        tick();
        set_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("odd_sw_mis",   32'(misalign_o), 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
